password_entry: RTL and testbench
=================================

# password_entry

Keypad-side front end for the combination lock. It takes digit, enter and clear strobes, compares entered digits against a stored password, and drives the `count` and `length` buses that the lock comparator checks for equality (`state = (count == length)`). It also handles password change while open and a lockout after repeated failures.

## Interface
- `MAX_LEN`, 7, maximum password length; fixed by the 3-bit `count`/`length` buses.
- `DIGIT_W`, 4, width of one keypad digit.
- `MAX_FAILS`, 3, consecutive failed attempts that trigger lockout.
- `LOCKOUT_CYCLES`, 1000, lockout duration in clock cycles.
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `key_valid`  in  1  one-cycle strobe; `key_digit` is valid.
- `key_digit`  in  DIGIT_W  digit value.
- `key_enter`  in  1  one-cycle strobe that commits the attempt or the new password.
- `key_clear`  in  1  one-cycle strobe that aborts entry or relocks.
- `set_mode`  in  1  level; on enter while OPEN, selects password change.
- `count`  out  3  committed number of correct leading digits.
- `length`  out  3  stored password length.
- `entered`  out  3  digits typed in the current attempt, saturating at 7.
- `locked_out`  out  1  high during lockout.

## Operation
**Password store**
- MAX_LEN × DIGIT_W registers `pw[0..6]`.
- Reset value: length 4, digits 1, 2, 3, 4; `pw[4..6]` = 0.

**States:** ENTRY, OPEN, SET, LOCKOUT.

**Input priority:** `key_clear` > `key_enter` > `key_valid`. Only the highest-priority strobe in a cycle acts.

**ENTRY**
- Running registers `run_cnt` (3 bit), `pos` (3 bit), sticky `bad`.
- On digit at `pos`:
  - `pos < length`, `!bad`, `key_digit == pw[pos]`: `run_cnt++`.
  - Otherwise: `bad = 1`, `run_cnt = 0`.
  - `pos` increments, saturating at 7.
  - With `pos` at 7, further digits set `bad`.
- On enter:
  - `run_cnt == length && !bad && pos == length`: `count <= length`, fail counter cleared, go to OPEN.
  - Otherwise: `count <= 0`, fail counter++. At MAX_FAILS the counter is cleared, the timer is loaded, and the block goes to LOCKOUT.
  - In both cases the running registers are cleared.
- On clear: running registers cleared; `count` unchanged (it is 0 in ENTRY); fail counter unchanged.

**OPEN**
- `count` holds `length`.
- Clear, or enter with `set_mode = 0`: `count <= 0`, go to ENTRY.
- Enter with `set_mode = 1`: go to SET; new-digit buffer and `pos` cleared; `count` stays equal to `length`.
- Digits are ignored.

**SET**
- Each digit is written to `newpw[pos]` and `pos++`. Digits after the 7th are ignored (`pos` stays 7).
- Enter:
  - `pos >= 1`: `pw <= newpw`, `length <= pos`, `count <= 0`, go to ENTRY.
  - `pos == 0`: discard, return to OPEN.
- Clear: discard the buffer, return to OPEN.

**LOCKOUT**
- All keys ignored; `count = 0`; `locked_out = 1`.
- The timer counts down from LOCKOUT_CYCLES−1 to 0, then the block goes to ENTRY.

**`entered`** mirrors `pos` in ENTRY and SET, and is 0 in OPEN and LOCKOUT.

**Reset (any time, including mid-SET or mid-lockout)**
- State ENTRY.
- `count = 0`, `length = 4`, `entered = 0`, `locked_out = 0`.
- Password restored to 1-2-3-4; fail counter, timer and buffers cleared.

## Timing
- All outputs are registered. A strobe sampled at edge N is reflected on the outputs immediately after edge N; the comparator's `state` follows combinationally in the same cycle.
- `count` changes only on enter, clear, set-commit, lockout entry and reset. It never changes on individual digits, so the lock cannot open before enter.
- Strobes may arrive back-to-back on consecutive cycles with no gap needed.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles:
  - The enter at edge N makes `locked_out` high from N.
  - `locked_out` falls at edge N+LOCKOUT_CYCLES.
  - A key at that edge is processed in ENTRY.
- `length` updates at the set-commit edge. `count` is 0 at that same edge, so the comparator is not momentarily equal with the new length.

## Test plan
- Default password: after reset, keys 1,2,3,4 then enter → `count = 4`, `length = 4`; equality holds from the cycle after enter.
- Wrong digit: 1,2,9,4, enter → `count = 0`, fail = 1. Also 1,2,3,4,5, enter (too long) → `count = 0`. And 1,2,3, enter (short) → `count = 0`.
- Lockout (MAX_FAILS = 3, LOCKOUT_CYCLES = 20):
  - Three bad enters → `locked_out` high for exactly 20 cycles.
  - Keys 1,2,3,4, enter during lockout → no effect.
  - The correct code afterward opens the lock.
- Password change:
  - Open, then `set_mode = 1` + enter, then 7,7 and enter → `length = 2`, `count = 0`.
  - 7,7, enter → `count = 2`.
  - Old 1,2,3,4 fails.
  - Enter with no digits in SET → back to OPEN with `count = 4`.
- Priority and reset:
  - Same-cycle `key_clear` + `key_enter` with a correct entry → cleared, `count` stays 0.
  - `rst_n` low mid-SET after 3 digits → `length = 4`, 1-2-3-4 opens again.

Source files
------------

// File: rtl/password_entry.sv
// password_entry: keypad front end for the combination lock.
// Compares typed digits against a stored password and drives the count/length
// buses that the lock comparator checks for equality. While open, a new
// password can be programmed. Repeated failures trigger a timed lockout.
//
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   key_valid    - one-cycle strobe qualifying key_digit
//   key_digit    - keypad digit value
//   key_enter    - one-cycle strobe committing an attempt or a new password
//   key_clear    - one-cycle strobe aborting entry or relocking
//   set_mode     - level; enter while open selects password change
//   count        - committed number of correct leading digits
//   length       - stored password length
//   entered      - digits typed in the current attempt / new password
//   locked_out   - high while keys are ignored after repeated failures
module password_entry #(
  parameter int unsigned MAX_LEN        = 7,
  parameter int unsigned DIGIT_W        = 4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_enter,
  input  logic               key_clear,
  input  logic               set_mode,
  output logic [2:0]         count,
  output logic [2:0]         length,
  output logic [2:0]         entered,
  output logic               locked_out
);

  localparam int unsigned LEN_W   = 3;
  localparam int unsigned FAIL_W  = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;
  localparam int unsigned TIMER_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int unsigned DEF_LEN = 4;

  typedef enum logic [1:0] {
    ST_ENTRY,
    ST_OPEN,
    ST_SET,
    ST_LOCKOUT
  } state_e;

  state_e               state_q, state_d, eff_state;
  logic [DIGIT_W-1:0]   pw_q    [MAX_LEN];
  logic [DIGIT_W-1:0]   pw_d    [MAX_LEN];
  logic [DIGIT_W-1:0]   newpw_q [MAX_LEN];
  logic [DIGIT_W-1:0]   newpw_d [MAX_LEN];
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     count_q, count_d;
  logic [LEN_W-1:0]     pos_q, pos_d;
  logic [LEN_W-1:0]     run_q, run_d;
  logic                 bad_q, bad_d;
  logic [FAIL_W-1:0]    fails_q, fails_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 locked_q, locked_d;

  // State and datapath registers; reset restores the 1-2-3-4 password.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ENTRY;
      for (int i = 0; i < MAX_LEN; i++) begin
        pw_q[i]    <= (i < DEF_LEN) ? DIGIT_W'(i + 1) : '0;
        newpw_q[i] <= '0;
      end
      len_q    <= LEN_W'(DEF_LEN);
      count_q  <= '0;
      pos_q    <= '0;
      run_q    <= '0;
      bad_q    <= 1'b0;
      fails_q  <= '0;
      timer_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pw_q     <= pw_d;
      newpw_q  <= newpw_d;
      len_q    <= len_d;
      count_q  <= count_d;
      pos_q    <= pos_d;
      run_q    <= run_d;
      bad_q    <= bad_d;
      fails_q  <= fails_d;
      timer_q  <= timer_d;
      locked_q <= locked_d;
    end
  end

  // Next-state logic. Key priority: clear > enter > digit.
  always_comb begin
    state_d  = state_q;
    pw_d     = pw_q;
    newpw_d  = newpw_q;
    len_d    = len_q;
    count_d  = count_q;
    pos_d    = pos_q;
    run_d    = run_q;
    bad_d    = bad_q;
    fails_d  = fails_q;
    timer_d  = timer_q;

    // The final lockout cycle behaves as ENTRY so a key on the release edge is not lost.
    eff_state = state_q;
    if (state_q == ST_LOCKOUT && timer_q == '0) begin
      eff_state = ST_ENTRY;
    end

    case (eff_state)
      ST_ENTRY: begin
        state_d = ST_ENTRY;
        if (key_clear) begin
          pos_d = '0;
          run_d = '0;
          bad_d = 1'b0;
        end else if (key_enter) begin
          if (run_q == len_q && !bad_q && pos_q == len_q) begin
            count_d = len_q;
            fails_d = '0;
            state_d = ST_OPEN;
          end else begin
            count_d = '0;
            if (fails_q == FAIL_W'(MAX_FAILS - 1)) begin
              fails_d = '0;
              timer_d = TIMER_W'(LOCKOUT_CYCLES - 1);
              state_d = ST_LOCKOUT;
            end else begin
              fails_d = fails_q + FAIL_W'(1);
            end
          end
          pos_d = '0;
          run_d = '0;
          bad_d = 1'b0;
        end else if (key_valid) begin
          if (pos_q < len_q && !bad_q && key_digit == pw_q[pos_q]) begin
            run_d = run_q + LEN_W'(1);
          end else begin
            bad_d = 1'b1;
            run_d = '0;
          end
          if (pos_q != LEN_W'(MAX_LEN)) begin
            pos_d = pos_q + LEN_W'(1);
          end
        end
      end

      ST_OPEN: begin
        if (key_clear || (key_enter && !set_mode)) begin
          count_d = '0;
          state_d = ST_ENTRY;
        end else if (key_enter) begin
          for (int i = 0; i < MAX_LEN; i++) begin
            newpw_d[i] = '0;
          end
          pos_d   = '0;
          state_d = ST_SET;
        end
      end

      ST_SET: begin
        if (key_clear) begin
          pos_d   = '0;
          state_d = ST_OPEN;
        end else if (key_enter) begin
          if (pos_q != '0) begin
            pw_d    = newpw_q;
            len_d   = pos_q;
            count_d = '0;
            state_d = ST_ENTRY;
          end else begin
            state_d = ST_OPEN;
          end
          pos_d = '0;
        end else if (key_valid && pos_q != LEN_W'(MAX_LEN)) begin
          newpw_d[pos_q] = key_digit;
          pos_d          = pos_q + LEN_W'(1);
        end
      end

      ST_LOCKOUT: begin
        timer_d = timer_q - TIMER_W'(1);
      end
    endcase

    locked_d = (state_d == ST_LOCKOUT);
  end

  // pos is held at zero outside ENTRY/SET, so it doubles as the entered count.
  assign count      = count_q;
  assign length     = len_q;
  assign entered    = pos_q;
  assign locked_out = locked_q;

endmodule

// File: tb/tb_password_entry.sv
// Scoreboard bench for password_entry: a sequence-level reference model
// predicts outputs per driven cycle; a monitor compares after each edge.
module tb_password_entry;

  localparam int unsigned LOCK_CYC = 20;
  localparam int unsigned MFAILS   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_enter = 1'b0;
  logic       key_clear = 1'b0;
  logic       set_mode = 1'b0;
  logic [2:0] count, length, entered;
  logic       locked_out;

  password_entry #(
    .MAX_LEN(7), .DIGIT_W(4), .MAX_FAILS(MFAILS), .LOCKOUT_CYCLES(LOCK_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_digit(key_digit),
    .key_enter(key_enter), .key_clear(key_clear), .set_mode(set_mode),
    .count(count), .length(length), .entered(entered), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] c;
    logic [2:0] l;
    logic [2:0] n;
    logic       lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: sequences of digits, not registers.
  int m_pw[$];
  int m_typed[$];
  int m_new[$];
  bit m_open, m_set;
  int m_fails;
  int m_edge = 0;
  int m_lock_until = 0;

  function automatic void cmp(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  function automatic bit same_seq();
    if (m_typed.size() != m_pw.size()) return 1'b0;
    foreach (m_pw[i]) if (m_typed[i] != m_pw[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_pw = '{1, 2, 3, 4};
    m_typed.delete();
    m_new.delete();
    m_open = 1'b0;
    m_set = 1'b0;
    m_fails = 0;
    m_lock_until = 0;
  endfunction

  function automatic void model_step(input bit v, input int d, input bit e, input bit c, input bit s);
    m_edge++;
    if (m_edge < m_lock_until) return;
    if (m_set) begin
      if (c) begin
        m_set = 1'b0;
        m_new.delete();
      end else if (e) begin
        if (m_new.size() > 0) begin
          m_pw = m_new;
          m_open = 1'b0;
          m_typed.delete();
        end
        m_set = 1'b0;
        m_new.delete();
      end else if (v && m_new.size() < 7) begin
        m_new.push_back(d);
      end
    end else if (m_open) begin
      if (c || (e && !s)) m_open = 1'b0;
      else if (e) begin
        m_set = 1'b1;
        m_new.delete();
      end
    end else begin
      if (c) m_typed.delete();
      else if (e) begin
        if (same_seq()) begin
          m_open = 1'b1;
          m_fails = 0;
        end else begin
          m_fails++;
          if (m_fails == MFAILS) begin
            m_fails = 0;
            m_lock_until = m_edge + LOCK_CYC;
          end
        end
        m_typed.delete();
      end else if (v) begin
        m_typed.push_back(d);
      end
    end
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    bit   lk;
    int   n;
    lk = (m_edge < m_lock_until);
    if (m_set) n = m_new.size();
    else if (m_open || lk) n = 0;
    else n = (m_typed.size() > 7) ? 7 : m_typed.size();
    x.c  = (m_open || m_set) ? 3'(m_pw.size()) : 3'd0;
    x.l  = 3'(m_pw.size());
    x.n  = 3'(n);
    x.lo = lk;
    return x;
  endfunction

  // One driven cycle: inputs change at negedge, expectation queued for the next posedge.
  task automatic drive(input bit v, input int d, input bit e, input bit c, input bit s);
    @(negedge clk);
    key_valid = v;
    key_digit = 4'(d);
    key_enter = e;
    key_clear = c;
    set_mode  = s;
    model_step(v, d, e, c, s);
    exp_q.push_back(model_out());
  endtask

  task automatic key(input int d);          drive(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic enter(input bit s);        drive(1'b0, 0, 1'b1, 1'b0, s);    endtask
  task automatic clr();                     drive(1'b0, 0, 1'b0, 1'b1, 1'b0); endtask
  task automatic idle(input int n);         repeat (n) drive(1'b0, 0, 1'b0, 1'b0, 1'b0); endtask
  task automatic code1234();                key(1); key(2); key(3); key(4); endtask

  task automatic do_reset();
    @(negedge clk);
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0; set_mode = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("rst_count", int'(count), 0);
    cmp("rst_length", int'(length), 4);
    cmp("rst_entered", int'(entered), 0);
    cmp("rst_locked", int'(locked_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per edge that had stimulus behind it.
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      cmp("count", int'(count), int'(x.c));
      cmp("length", int'(length), int'(x.l));
      cmp("entered", int'(entered), int'(x.n));
      cmp("locked_out", int'(locked_out), int'(x.lo));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bit v, e, c, s;
    do_reset();

    // Default password opens; then relock.
    code1234(); enter(1'b0); idle(2); enter(1'b0);

    // Wrong digit, too long, too short -> third failure locks out.
    key(1); key(2); key(9); key(4); enter(1'b0);
    code1234(); key(5); enter(1'b0);
    key(1); key(2); key(3); enter(1'b0);
    code1234(); enter(1'b0);          // ignored while locked
    idle(LOCK_CYC - 6);
    code1234(); enter(1'b0);          // first key lands on the release edge
    idle(1);

    // Empty SET returns to OPEN with count unchanged.
    enter(1'b1); enter(1'b0); idle(1);
    // Change password to 7,7.
    enter(1'b1); key(7); key(7); enter(1'b0); idle(1);
    key(7); key(7); enter(1'b0); idle(1); clr();
    code1234(); enter(1'b0); idle(1);

    // Eight digits in SET saturate at seven.
    key(7); key(7); enter(1'b0);
    enter(1'b1);
    for (int i = 0; i < 8; i++) key(i + 2);
    enter(1'b0);
    for (int i = 0; i < 7; i++) key(i + 2);
    enter(1'b0); clr();

    // Clear beats enter in the same cycle.
    do_reset();
    code1234(); drive(1'b0, 0, 1'b1, 1'b1, 1'b0); idle(1);

    // Reset mid-SET restores the default password.
    code1234(); enter(1'b0); enter(1'b1); key(5); key(6); key(8);
    do_reset();
    code1234(); enter(1'b0); idle(1); clr();

    // Random strobes, biased toward the correct next digit.
    for (int k = 0; k < 3000; k++) begin
      c = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 7) == 0);
      v = $urandom_range(0, 1);
      s = $urandom_range(0, 1);
      if (!m_open && !m_set && m_typed.size() < m_pw.size() && $urandom_range(0, 3) != 0)
        d = m_pw[m_typed.size()];
      else
        d = $urandom_range(0, 15);
      drive(v, d, e, c, s);
    end

    idle(2);
    @(negedge clk);
    key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
